// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard controller for an in-order pipeline. It tracks the destination
//   records of the NSTG post-decode stages (stage 1 = EX, stage NSTG = WB),
//   stalls ID on a load-use dependency, picks EX operand forward sources,
//   squashes IF/ID on a taken branch, and freezes while data memory is busy.
//
// Ports
//   clk_i, rst_i               clock, async active-low reset
//   id_valid_i                 ID holds a real instruction
//   id_rs_i/id_rt_i            ID source registers
//   id_use_rs_i/id_use_rt_i    source actually read
//   id_wr_i/id_rd_i/id_load_i  ID destination write, address, load flag
//   br_taken_i                 branch/jump resolved taken in ID
//   mem_busy_i                 data memory not ready; freeze everything
//   pc_write_o/ifid_write_o    PC and IF/ID update enables
//   ifid_flush_o               clear IF/ID
//   bubble_o                   zero ID control into ID/EX
//   fwd_a_o/fwd_b_o            EX operand source: 0 = reg file, k = stage k+1
//   stall_cnt_o/flush_cnt_o    saturating event counters
//
// Build option
//   PIPE_HAZARD_CTRL_STATS_EN  enables the stall/flush counters; without it
//                              both counter outputs are tied to zero.

module pipe_hazard_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int NSTG     = 3,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [ADDR_W-1:0] id_rs_i,
  input  logic [ADDR_W-1:0] id_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic              id_wr_i,
  input  logic [ADDR_W-1:0] id_rd_i,
  input  logic              id_load_i,
  input  logic              br_taken_i,
  input  logic              mem_busy_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              bubble_o,
  output logic [SEL_W-1:0]  fwd_a_o,
  output logic [SEL_W-1:0]  fwd_b_o,
  output logic [15:0]       stall_cnt_o,
  output logic [15:0]       flush_cnt_o
);

  // Stage records. Load flags only matter where a load is not yet
  // forwardable, so they are kept for stages 1..LOAD_LAT only.
  logic [NSTG:1]     st_valid;
  logic [NSTG:1]     st_wr;
  logic [LOAD_LAT:1] st_load;
  logic [ADDR_W-1:0] st_rd [1:NSTG];
  logic [ADDR_W-1:0] ex_rs;
  logic [ADDR_W-1:0] ex_rt;
  logic              ex_use_rs;
  logic              ex_use_rt;

  logic hazard;
  logic busy;

  // Busy is masked by reset so the reset-time outputs stay at their
  // "empty pipeline" values regardless of mem_busy_i.
  assign busy = mem_busy_i & rst_i;

  always_comb begin
    hazard = 1'b0;
    for (int k = 1; k <= LOAD_LAT; k++) begin
      if (st_valid[k] && st_load[k] && st_wr[k] && (st_rd[k] != '0) &&
          ((id_use_rs_i && (st_rd[k] == id_rs_i)) ||
           (id_use_rt_i && (st_rd[k] == id_rt_i)))) begin
        hazard = 1'b1;
      end
    end
    hazard = hazard & id_valid_i;
  end

  assign pc_write_o   = ~(busy | hazard);
  assign ifid_write_o = ~(busy | hazard);
  assign bubble_o     = hazard & ~busy;
  assign ifid_flush_o = br_taken_i & id_valid_i & ~hazard & ~busy & rst_i;

  // Only valid bits need reset; data fields are don't-care while invalid.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      st_valid <= '0;
    end else if (!mem_busy_i) begin
      st_valid <= {st_valid[NSTG-1:1], id_valid_i & ~hazard};
    end
  end

  // A bubble also clears its control bits so a squashed slot can never
  // request a forward or look like a pending load.
  always_ff @(posedge clk_i) begin
    if (!mem_busy_i) begin
      ex_rs      <= id_rs_i;
      ex_rt      <= id_rt_i;
      ex_use_rs  <= id_use_rs_i & ~hazard;
      ex_use_rt  <= id_use_rt_i & ~hazard;
      st_wr[1]   <= id_wr_i & ~hazard;
      st_rd[1]   <= id_rd_i;
      st_load[1] <= id_load_i & ~hazard;
      for (int k = 2; k <= NSTG; k++) begin
        st_wr[k] <= st_wr[k-1];
        st_rd[k] <= st_rd[k-1];
      end
      for (int k = 2; k <= LOAD_LAT; k++) begin
        st_load[k] <= st_load[k-1];
      end
    end
  end

  // Walk from the oldest stage to the youngest so the youngest match wins.
  always_comb begin
    fwd_a_o = '0;
    fwd_b_o = '0;
    for (int k = NSTG; k >= 2; k--) begin
      if (st_valid[k] && st_wr[k] && (st_rd[k] != '0)) begin
        if (ex_use_rs && (st_rd[k] == ex_rs)) fwd_a_o = SEL_W'(k - 1);
        if (ex_use_rt && (st_rd[k] == ex_rt)) fwd_b_o = SEL_W'(k - 1);
      end
    end
  end

`ifdef PIPE_HAZARD_CTRL_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((hazard || mem_busy_i) && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (ifid_flush_o && (flush_cnt != 16'hFFFF))
        flush_cnt <= flush_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
`else
  assign stall_cnt_o = 16'h0000;
  assign flush_cnt_o = 16'h0000;
`endif

endmodule
